// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline writeback and the mul/div unit,
// and keeps the multi-cycle reservation scoreboard. Rev 1.0
`default_nettype none

module rf_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [ADDR_W-1:0]     wb0_rd,
  input  logic [DATA_W-1:0]     wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [ADDR_W-1:0]     wb1_rd,
  input  logic [DATA_W-1:0]     wb1_data,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_W-1:0]     iss_rd,
  input  logic [ADDR_W-1:0]     chk_rs,
  input  logic [ADDR_W-1:0]     chk_rt,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic [2**ADDR_W-1:0]  busy_vec,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_wa,
  output logic [DATA_W-1:0]     rf_wd
);

  localparam int                NREG       = 2**ADDR_W;
  localparam int                CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  C_MAX_WAIT = CNT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] C_R0       = '0;

  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
  logic              force_grant, gnt0, gnt1;

  always_comb begin
    force_grant = (wait_cnt_q >= C_MAX_WAIT);
    wb1_ready   = ~wb0_valid | force_grant;
    wb0_ready   = ~(wb1_valid & force_grant);
    gnt1        = wb1_valid & wb1_ready;
    gnt0        = wb0_valid & wb0_ready;
  end

  // Port 1 only accumulates wait while it is actually requesting and blocked.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt1 || !wb1_valid) begin
      wait_cnt_d = '0;
    end else if (!force_grant) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (gnt1) begin
      rf_we_d = (wb1_rd != C_R0);
      rf_wa_d = wb1_rd;
      rf_wd_d = wb1_data;
    end else if (gnt0) begin
      rf_we_d = (wb0_rd != C_R0);
      rf_wa_d = wb0_rd;
      rf_wd_d = wb0_data;
    end
  end

  always_comb begin
    iss_ready = ~busy_q[iss_rd] | (iss_rd == C_R0);
  end

  // A same-register issue is refused while busy, so set and clear never collide.
  always_comb begin
    busy_d = busy_q;
    if (iss_valid && iss_ready && (iss_rd != C_R0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (gnt1 && (wb1_rd != C_R0)) begin
      busy_d[wb1_rd] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

  always_comb begin
    rs_busy  = busy_q[chk_rs];
    rt_busy  = busy_q[chk_rt];
    busy_vec = {busy_q[NREG-1:1], 1'b0};
    rf_we    = rf_we_q;
    rf_wa    = rf_wa_q;
    rf_wd    = rf_wd_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model. Rev 1.0
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rd, chk_rs, chk_rt;
  logic        rs_busy, rt_busy;
  logic [31:0] busy_vec;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int          m_wait;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .busy_vec(busy_vec), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  // Expected ready/busy signals from the model state and present inputs.
  function automatic logic [36:0] model_comb();
    logic starving, r0, r1, ir;
    starving = (m_wait >= MAX_WAIT);
    r1 = !wb0_valid || starving;
    r0 = !(wb1_valid && starving);
    ir = (m_busy[iss_rd] == 1'b0) || (iss_rd == 5'd0);
    return {r0, r1, ir, m_busy[chk_rs], m_busy[chk_rt], m_busy};
  endfunction

  task automatic model_edge();
    logic starving, g0, g1, ir;
    starving = (m_wait >= MAX_WAIT);
    g1 = wb1_valid && (!wb0_valid || starving);
    g0 = wb0_valid && !g1;
    ir = (m_busy[iss_rd] == 1'b0) || (iss_rd == 5'd0);
    if (reset) begin
      m_wait = 0; m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      m_we = 1'b0;
      if (g1) begin m_we = (wb1_rd != 0); m_wa = wb1_rd; m_wd = wb1_data; end
      else if (g0) begin m_we = (wb0_rd != 0); m_wa = wb0_rd; m_wd = wb0_data; end
      if (g1 || !wb1_valid) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
      if (iss_valid && ir && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (g1 && wb1_rd != 0) m_busy[wb1_rd] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0; iss_valid = 1'b0;
    wb0_rd = '0; wb1_rd = '0; iss_rd = '0; wb0_data = '0; wb1_data = '0;
    chk_rs = '0; chk_rt = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_total++;
    if ({rf_we, rf_wa, rf_wd, busy_vec} !== 70'd0)
      $display("FAIL reset_state: got we=%b wa=%0d wd=%h busy=%h, want all 0", rf_we, rf_wa, rf_wd, busy_vec);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({wb0_ready, wb1_ready, iss_ready} !== 3'b111)
      $display("FAIL reset_ready: got %b, want 111", {wb0_ready, wb1_ready, iss_ready});
    else n_pass++;
  endtask

  task automatic test_single_write();
    idle();
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'h12345678;
    @(negedge clk);
    n_total++;
    if (wb0_ready !== 1'b1) $display("FAIL single_ready: got %b, want 1", wb0_ready);
    else n_pass++;
    tick();
    idle();
    n_total++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'h12345678})
      $display("FAIL single_write: got we=%b wa=%0d wd=%h, want 1/5/12345678", rf_we, rf_wa, rf_wd);
    else n_pass++;
    tick();
    n_total++;
    if (rf_we !== 1'b0) $display("FAIL single_we_drop: got %b, want 0", rf_we);
    else n_pass++;
  endtask

  task automatic test_starvation();
    idle();
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h33;
    wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h77;
    for (int c = 0; c <= MAX_WAIT + 1; c++) begin
      @(negedge clk);
      n_total++;
      if ({wb0_ready, wb1_ready} !== ((c == MAX_WAIT) ? 2'b01 : 2'b10))
        $display("FAIL starve_ready c=%0d: got r0r1=%b%b", c, wb0_ready, wb1_ready);
      else n_pass++;
      tick();
      n_total++;
      if ({rf_we, rf_wa} !== {1'b1, (c == MAX_WAIT) ? 5'd7 : 5'd3})
        $display("FAIL starve_wa c=%0d: got we=%b wa=%0d", c, rf_we, rf_wa);
      else n_pass++;
    end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9; chk_rs = 5'd9;
    @(negedge clk);
    n_total++;
    if ({iss_ready, rs_busy} !== 2'b10) $display("FAIL sb_first_issue: got rdy/busy=%b%b, want 10", iss_ready, rs_busy);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if ({iss_ready, rs_busy, busy_vec[9]} !== 3'b011)
      $display("FAIL sb_second_issue: got rdy/rs/bv=%b%b%b, want 011", iss_ready, rs_busy, busy_vec[9]);
    else n_pass++;
    tick();
    iss_valid = 1'b0;
    wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'hAA;
    tick();
    idle(); chk_rs = 5'd9;
    #1;
    n_total++;
    if ({busy_vec[9], rs_busy, rf_we, rf_wa, rf_wd} !== {1'b0, 1'b0, 1'b1, 5'd9, 32'hAA})
      $display("FAIL sb_clear: got bv9=%b rs=%b we=%b wa=%0d wd=%h, want 0 0 1 9 aa",
               busy_vec[9], rs_busy, rf_we, rf_wa, rf_wd);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h55;
    @(negedge clk);
    n_total++;
    if (iss_ready !== 1'b0) $display("FAIL same_refuse: got iss_ready=%b, want 0", iss_ready);
    else n_pass++;
    tick();
    wb1_valid = 1'b0;
    n_total++;
    if ({busy_vec[9], rf_we, rf_wa} !== {1'b0, 1'b1, 5'd9})
      $display("FAIL same_clear: got bv9=%b we=%b wa=%0d, want 0 1 9", busy_vec[9], rf_we, rf_wa);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (iss_ready !== 1'b1) $display("FAIL same_retry_ready: got %b, want 1", iss_ready);
    else n_pass++;
    tick();
    iss_valid = 1'b0;
    n_total++;
    if (busy_vec[9] !== 1'b1) $display("FAIL same_retry_set: got bv9=%b, want 1", busy_vec[9]);
    else n_pass++;
    wb1_valid = 1'b1; wb1_rd = 5'd9;
    tick();
    idle();
  endtask

  task automatic test_reg0();
    idle();
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'hDEAD;
    @(negedge clk);
    n_total++;
    if (wb1_ready !== 1'b1) $display("FAIL reg0_wb_ready: got %b, want 1", wb1_ready);
    else n_pass++;
    tick();
    wb1_valid = 1'b0;
    n_total++;
    if (rf_we !== 1'b0) $display("FAIL reg0_we: got %b, want 0", rf_we);
    else n_pass++;
    iss_valid = 1'b1; iss_rd = 5'd0; chk_rs = 5'd0;
    @(negedge clk);
    n_total++;
    if (iss_ready !== 1'b1) $display("FAIL reg0_iss_ready: got %b, want 1", iss_ready);
    else n_pass++;
    tick();
    iss_valid = 1'b0;
    n_total++;
    if ({busy_vec, rs_busy, rf_we} !== 34'd0)
      $display("FAIL reg0_busy: got bv=%h rs=%b we=%b, want 0", busy_vec, rs_busy, rf_we);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd4; tick();
    iss_rd = 5'd6; tick();
    iss_valid = 1'b0;
    n_total++;
    if (busy_vec !== 32'h50) $display("FAIL mid_reserve: got %h, want 00000050", busy_vec);
    else n_pass++;
    wb0_valid = 1'b1; wb0_rd = 5'd2; wb0_data = 32'h22;
    wb1_valid = 1'b1; wb1_rd = 5'd8; wb1_data = 32'h88;
    tick(); tick();
    wb1_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (wb0_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b, want 1", wb0_ready);
    else n_pass++;
    tick();
    reset = 1'b0; wb0_valid = 1'b0;
    n_total++;
    if ({busy_vec, rf_we} !== 33'd0) $display("FAIL mid_after_reset: got bv=%h we=%b, want 0", busy_vec, rf_we);
    else n_pass++;
    tick();
    n_total++;
    if (rf_we !== 1'b0) $display("FAIL mid_we_stays: got %b, want 0", rf_we);
    else n_pass++;
    wb0_valid = 1'b1; wb1_valid = 1'b1;
    for (int c = 0; c <= MAX_WAIT; c++) begin
      @(negedge clk);
      n_total++;
      if (wb1_ready !== (c == MAX_WAIT))
        $display("FAIL mid_wait_cleared c=%0d: got wb1_ready=%b", c, wb1_ready);
      else n_pass++;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      reset     = ($urandom_range(63) == 0);
      wb0_valid = ($urandom_range(9) < 7);
      wb1_valid = ($urandom_range(1) == 1);
      iss_valid = ($urandom_range(1) == 1);
      wb0_rd    = 5'($urandom_range(7));
      wb1_rd    = 5'($urandom_range(7));
      iss_rd    = 5'($urandom_range(7));
      chk_rs    = 5'($urandom_range(7));
      chk_rt    = 5'($urandom_range(7));
      wb0_data  = $urandom;
      wb1_data  = $urandom;
      @(negedge clk);
      n_total++;
      if ({wb0_ready, wb1_ready, iss_ready, rs_busy, rt_busy, busy_vec} !== model_comb())
        $display("FAIL rand_comb n=%0d: got %h, want %h", n,
                 {wb0_ready, wb1_ready, iss_ready, rs_busy, rt_busy, busy_vec}, model_comb());
      else n_pass++;
      tick();
      n_total++;
      if ({rf_we, rf_wa, rf_wd} !== {m_we, m_wa, m_wd})
        $display("FAIL rand_out n=%0d: got we=%b wa=%0d wd=%h, want we=%b wa=%0d wd=%h",
                 n, rf_we, rf_wa, rf_wd, m_we, m_wa, m_wd);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    m_wait = 0; m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    idle();
    test_reset();
    test_single_write();
    test_starvation();
    test_scoreboard();
    test_same_cycle();
    test_reg0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
